// File: rtl/base_sram_cntrs_rc.sv
// Statistics counter array: per-channel local accumulators are flushed into one
// SRAM (base_mem) by a round-robin read-modify-write scanner. Reads are served
// through a two-stage valid/ready output pipeline with optional read-and-clear.
module base_sram_cntrs_rc #(
    parameter int unsigned width      = 32,
    parameter int unsigned n          = 4,
    parameter int unsigned addr_width = $clog2(n),
    parameter int unsigned inc_width  = 1,
    parameter int unsigned sat        = 0,
    parameter int unsigned lw         = addr_width + inc_width + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [n-1:0]               i_inc_v,
    input  logic [n*inc_width-1:0]     i_inc_d,
    input  logic                       i_rd_v,
    output logic                       i_rd_r,
    input  logic [addr_width-1:0]      i_rd_a,
    input  logic                       i_rd_clr,
    output logic                       o_rd_v,
    input  logic                       o_rd_r,
    output logic [width-1:0]           o_rd_d,
    output logic                       o_init_done
);

    localparam int unsigned SW = addr_width + 1;
    localparam logic [addr_width-1:0] LastAddr = addr_width'(n - 1);

    // Scanner {addr, sel}: sel=1 is a flush slot for addr, sel=0 a read slot.
    logic [SW-1:0]         scan_q, scan_d;
    logic [addr_width-1:0] scan_addr;
    logic                  scan_sel;
    logic                  wrapped_q, wrapped_d;

    logic [lw-1:0] acc_q [n];
    logic [lw-1:0] acc_d [n];

    // Flush pipeline; the first bit marks writes from the initial pass.
    logic                  s0_v_q, s1_v_q, s2_v_q;
    logic [addr_width-1:0] s0_a_q, s1_a_q, s2_a_q;
    logic [lw-1:0]         s0_acc_q, s1_acc_q, s2_acc_q;
    logic                  s0_first_q, s1_first_q, s2_first_q;

    logic [width-1:0] base_mem [n];
    logic [width-1:0] fl_rd_q;
    logic [width-1:0] rd_mem_q;
    logic [width-1:0] base;
    logic [width:0]   wsum;
    logic [width-1:0] wd;

    logic [n-1:0] pclr_q, pclr_d;
    logic         init_done_q, init_done_d;

    // Output pipeline: request stage (SRAM data in flight) and data stage.
    logic             req_v_q, req_v_d;
    logic             req_byp_q, req_byp_d;
    logic [width-1:0] req_bd_q, req_bd_d;
    logic [width-1:0] req_val;
    logic             req_adv;
    logic             out_v_q, out_v_d;
    logic [width-1:0] out_d_q, out_d_d;
    logic             rd_fire;

    assign scan_addr   = scan_q[SW-1:1];
    assign scan_sel    = scan_q[0];
    assign o_rd_v      = out_v_q;
    assign o_rd_d      = out_d_q;
    assign o_init_done = init_done_q;

    // Next-state logic for scanner, accumulators, write data and read path.
    always_comb begin
        scan_d    = (scan_sel && scan_addr == LastAddr) ? '0 : scan_q + 1'b1;
        wrapped_d = wrapped_q | (scan_sel && scan_addr == LastAddr);

        // Increments in the capture cycle land in the fresh accumulation.
        for (int i = 0; i < n; i++) begin
            acc_d[i] = (scan_sel && scan_addr == addr_width'(i)) ? '0 : acc_q[i];
            if (i_inc_v[i]) begin
                acc_d[i] = acc_d[i] + lw'(i_inc_d[i*inc_width +: inc_width]);
            end
        end

        base = (s2_first_q || pclr_q[s2_a_q]) ? '0 : fl_rd_q;
        wsum = {1'b0, base} + (width + 1)'(s2_acc_q);
        wd   = wsum[width-1:0];
        if (sat != 0 && wsum[width]) begin
            wd = '1;
        end

        req_val = req_byp_q ? req_bd_q : rd_mem_q;
        req_adv = req_v_q && (!out_v_q || o_rd_r);
        i_rd_r  = init_done_q && !scan_sel && (!req_v_q || req_adv);
        rd_fire = i_rd_v && i_rd_r;

        req_v_d   = rd_fire ? 1'b1 : (req_adv ? 1'b0 : req_v_q);
        req_byp_d = req_byp_q;
        req_bd_d  = req_bd_q;
        if (rd_fire) begin
            // Same-cycle flush write to this address is not yet in base_mem.
            req_byp_d = s2_v_q && (s2_a_q == i_rd_a);
            req_bd_d  = wd;
        end

        out_v_d = out_v_q;
        out_d_d = out_d_q;
        if (req_adv) begin
            out_v_d = 1'b1;
            out_d_d = req_val;
        end else if (o_rd_r) begin
            out_v_d = 1'b0;
        end

        // A clear accepted alongside the write wins, so the next flush is local-only.
        pclr_d = pclr_q;
        if (s2_v_q) begin
            pclr_d[s2_a_q] = 1'b0;
        end
        if (rd_fire && i_rd_clr) begin
            pclr_d[i_rd_a] = 1'b1;
        end

        init_done_d = init_done_q | (s2_v_q && s2_first_q && s2_a_q == LastAddr);
    end

    // Control and pipeline state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q      <= '0;
            wrapped_q   <= 1'b0;
            for (int i = 0; i < n; i++) begin
                acc_q[i] <= '0;
            end
            s0_v_q      <= 1'b0;
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s0_a_q      <= '0;
            s1_a_q      <= '0;
            s2_a_q      <= '0;
            s0_acc_q    <= '0;
            s1_acc_q    <= '0;
            s2_acc_q    <= '0;
            s0_first_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            pclr_q      <= '0;
            init_done_q <= 1'b0;
            req_v_q     <= 1'b0;
            req_byp_q   <= 1'b0;
            req_bd_q    <= '0;
            out_v_q     <= 1'b0;
            out_d_q     <= '0;
        end else begin
            scan_q      <= scan_d;
            wrapped_q   <= wrapped_d;
            for (int i = 0; i < n; i++) begin
                acc_q[i] <= acc_d[i];
            end
            s0_v_q      <= scan_sel;
            s0_a_q      <= scan_addr;
            s0_acc_q    <= acc_q[scan_addr];
            s0_first_q  <= !wrapped_q;
            s1_v_q      <= s0_v_q;
            s1_a_q      <= s0_a_q;
            s1_acc_q    <= s0_acc_q;
            s1_first_q  <= s0_first_q;
            s2_v_q      <= s1_v_q;
            s2_a_q      <= s1_a_q;
            s2_acc_q    <= s1_acc_q;
            s2_first_q  <= s1_first_q;
            pclr_q      <= pclr_d;
            init_done_q <= init_done_d;
            req_v_q     <= req_v_d;
            req_byp_q   <= req_byp_d;
            req_bd_q    <= req_bd_d;
            out_v_q     <= out_v_d;
            out_d_q     <= out_d_d;
        end
    end

    // SRAM array: flush write, flush read (s1) and request read ports.
    always_ff @(posedge clk) begin
        if (s2_v_q) begin
            base_mem[s2_a_q] <= wd;
        end
        if (s1_v_q) begin
            fl_rd_q <= base_mem[s1_a_q];
        end
        if (rd_fire) begin
            rd_mem_q <= base_mem[i_rd_a];
        end
    end

endmodule
